// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, widths and FIPS-197 reference vectors.
package aes_pkg;

    localparam int AES_KEY_W  = 128;
    localparam int AES_ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READY = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // FIPS-197 Appendix A.1 key and selected expanded round keys
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

endpackage

// File: rtl/aes_rk_mux.sv
// Registered round-key response stage: one cycle from rk_req to rk_valid, requests dropped
// unless key_ready; out-of-range indices answer with rk_err and zero data.
module aes_rk_mux
    import aes_pkg::*;
#(
    parameter int ROUNDS_P = 10
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 key_ready,
    input  logic                                 rk_req,
    input  logic [3:0]                           rk_round,
    input  logic [(ROUNDS_P+1)*AES_KEY_W-1:0]    exp_key,
    output logic                                 rk_valid,
    output logic [AES_KEY_W-1:0]                 rk_data,
    output logic                                 rk_err
);

    logic [AES_KEY_W-1:0] sel_key;
    logic                 in_range;

    always_comb begin
        sel_key  = '0;
        in_range = 1'b0;
        for (int r = 0; r <= ROUNDS_P; r++) begin
            if (rk_round == 4'(r)) begin
                sel_key  = exp_key[r*AES_KEY_W +: AES_KEY_W];
                in_range = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_err   <= 1'b0;
        end else begin
            rk_valid <= rk_req && key_ready;
            rk_err   <= rk_req && key_ready && !in_range;
            rk_data  <= (rk_req && key_ready && in_range) ? sel_key : '0;
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequences the AES-128 key expansion engine under a watchdog and serves round keys
// to the cipher core; a re-offered identical key is acked from the cache without re-expansion.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int ROUNDS_P   = 10,
    parameter int TIMEOUT_P  = 64,
    parameter int CACHE_EN_P = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 key_valid,
    input  logic [AES_KEY_W-1:0]                 key,
    output logic                                 key_ack,
    output logic                                 ke_reset,
    output logic                                 ke_start,
    output logic [AES_KEY_W-1:0]                 ke_key,
    input  logic [(ROUNDS_P+1)*AES_KEY_W-1:0]    ke_exp_key,
    input  logic                                 ke_done,
    input  logic                                 rk_req,
    input  logic [3:0]                           rk_round,
    output logic                                 rk_valid,
    output logic [AES_KEY_W-1:0]                 rk_data,
    output logic                                 rk_err,
    output logic                                 key_ready,
    output logic                                 busy,
    output logic                                 err
);

    localparam int              WD_W    = $clog2(TIMEOUT_P) + 1;
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    // The count reaches TIMEOUT_P-1 on the edge that enters ERROR, so err rises
    // exactly TIMEOUT_P cycles after the ke_start cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_P - 2);

    state_t          state;
    logic [WD_W-1:0] wd;
    logic            cache_valid;
    logic            accept;
    logic            cache_hit;

    // key_ack is still high while the requester sees it, so it must not re-accept
    assign accept    = key_valid && !key_ack;
    assign cache_hit = (CACHE_EN_P != 0) && cache_valid && (key == ke_key);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            key_ack     <= 1'b0;
            ke_reset    <= 1'b1;
            ke_start    <= 1'b0;
            ke_key      <= '0;
            key_ready   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            cache_valid <= 1'b0;
            wd          <= '0;
        end else begin
            key_ack  <= 1'b0;
            ke_reset <= 1'b0;
            ke_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        key_ack  <= 1'b1;
                        ke_key   <= key;
                        ke_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    wd    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wd != WD_MAX) wd <= wd + 1'b1;
                    if (ke_done) begin
                        busy        <= 1'b0;
                        key_ready   <= 1'b1;
                        cache_valid <= 1'b1;
                        state       <= ST_READY;
                    end else if (wd >= WD_LAST) begin
                        busy        <= 1'b0;
                        err         <= 1'b1;
                        cache_valid <= 1'b0;
                        state       <= ST_ERROR;
                    end
                end
                ST_READY: begin
                    if (accept) begin
                        key_ack <= 1'b1;
                        if (!cache_hit) begin
                            ke_key      <= key;
                            key_ready   <= 1'b0;
                            cache_valid <= 1'b0;
                            ke_start    <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ST_START;
                        end
                    end
                end
                ST_ERROR: begin
                    // Recovery takes two steps: engine reset cycle, then a fresh start
                    if (ke_reset) begin
                        ke_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end else if (accept) begin
                        key_ack  <= 1'b1;
                        ke_key   <= key;
                        ke_reset <= 1'b1;
                        err      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    aes_rk_mux #(
        .ROUNDS_P (ROUNDS_P)
    ) u_rk_mux (
        .clock     (clock),
        .reset     (reset),
        .key_ready (key_ready),
        .rk_req    (rk_req),
        .rk_round  (rk_round),
        .exp_key   (ke_exp_key),
        .rk_valid  (rk_valid),
        .rk_data   (rk_data),
        .rk_err    (rk_err)
    );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed/random bench for aes_key_sched_ctrl with a behavioural AES key-expansion engine model.
module tb_aes_key_sched_ctrl;
    import aes_pkg::*;

    localparam int ROUNDS = 10;
    localparam int TMO    = 64;
    localparam int BUS_W  = (ROUNDS + 1) * 128;

    logic              clk, rst_n;
    logic              key_valid;
    logic [127:0]      key;
    logic              key_ack, ke_reset, ke_start;
    logic [127:0]      ke_key;
    logic [BUS_W-1:0]  ke_exp_key;
    logic              ke_done;
    logic              rk_req;
    logic [3:0]        rk_round;
    logic              rk_valid;
    logic [127:0]      rk_data;
    logic              rk_err, key_ready, busy, err;

    int total = 0;
    int bad   = 0;
    int eng_delay = -1;
    int eng_cnt   = -1;

    logic [7:0]        sbox [256];
    logic [127:0]      model_key;
    logic [BUS_W-1:0]  model_exp;
    logic              model_ready;

    aes_key_sched_ctrl #(.ROUNDS_P(ROUNDS), .TIMEOUT_P(TMO), .CACHE_EN_P(1)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .key_valid  (key_valid),
        .key        (key),
        .key_ack    (key_ack),
        .ke_reset   (ke_reset),
        .ke_start   (ke_start),
        .ke_key     (ke_key),
        .ke_exp_key (ke_exp_key),
        .ke_done    (ke_done),
        .rk_req     (rk_req),
        .rk_round   (rk_round),
        .rk_valid   (rk_valid),
        .rk_data    (rk_data),
        .rk_err     (rk_err),
        .key_ready  (key_ready),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic logic [BUS_W-1:0] expand(input logic [127:0] k);
        logic [31:0]      w [44];
        logic [31:0]      t;
        logic [7:0]       rc = 8'h01;
        logic [BUS_W-1:0] bus = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= ROUNDS; r++)
            bus[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return bus;
    endfunction

    // Expansion engine model: ke_done eng_delay cycles after the ke_start cycle; -1 never finishes
    initial begin
        ke_done    = 1'b0;
        ke_exp_key = '0;
        forever begin
            @(posedge clk);
            #1;
            ke_done = 1'b0;
            if (ke_reset === 1'b1) eng_cnt = -1;
            else if (ke_start === 1'b1) eng_cnt = eng_delay;
            else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    ke_done    = 1'b1;
                    ke_exp_key = expand(ke_key);
                    eng_cnt    = -1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rk_check(input logic [3:0] r, input string tag);
        logic [127:0] exp;
        int idx = int'(r);
        rk_req   = 1'b1;
        rk_round = r;
        tick();
        rk_req = 1'b0;
        exp = (model_ready && idx <= ROUNDS) ? model_exp[idx*128 +: 128] : 128'h0;
        chk({tag, ".valid"}, rk_valid, model_ready);
        chk({tag, ".err"},   rk_err,   model_ready && idx > ROUNDS);
        chk({tag, ".data"},  rk_data,  exp);
    endtask

    task automatic wait_ready(input int n0, output int n);
        n = n0;
        do begin
            tick();
            n++;
        end while (!key_ready && n < 300);
    endtask

    task automatic start_load(input logic [127:0] k, input int d, input string tag);
        eng_delay = d;
        key       = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        chk({tag, ".ack"},   key_ack,   1'b1);
        chk({tag, ".start"}, ke_start,  1'b1);
        chk({tag, ".busy"},  busy,      1'b1);
        chk({tag, ".kekey"}, ke_key,    k);
        chk({tag, ".kr"},    key_ready, 1'b0);
        model_key   = k;
        model_ready = 1'b0;
    endtask

    task automatic finish_load(input int d, input int n0, input string tag);
        int n;
        wait_ready(n0, n);
        chk({tag, ".lat"},  n,    d + 1);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".err"},  err,  1'b0);
        model_exp   = expand(model_key);
        model_ready = 1'b1;
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int n, d;
        logic early;
        logic [127:0] k;
        logic [7:0] inv;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst_n = 1'b0; key_valid = 1'b0; key = '0; rk_req = 1'b0; rk_round = '0;
        model_key = '0; model_exp = '0; model_ready = 1'b0;

        // Reset state
        tick();
        chk("rst.ke_reset", ke_reset, 1'b1);
        chk("rst.key_ack", key_ack, 1'b0);
        chk("rst.ke_start", ke_start, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.key_ready", key_ready, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.rk_valid", rk_valid, 1'b0);
        chk("rst.ke_key", ke_key, 128'h0);
        rst_n = 1'b1;
        tick();
        chk("rst.ke_reset_rel", ke_reset, 1'b0);

        // Basic load with the FIPS-197 key
        start_load(FIPS_KEY, 5, "basic");
        tick();
        chk("basic.start_pulse", ke_start, 1'b0);
        chk("basic.ack_pulse", key_ack, 1'b0);
        chk("basic.busy_wait", busy, 1'b1);
        finish_load(5, 1, "basic");
        rk_check(4'd0, "rk0");
        chk("rk0.fips", rk_data, FIPS_KEY);
        rk_check(4'd1, "rk1");
        chk("rk1.fips", rk_data, FIPS_RK1);
        rk_check(4'd10, "rk10");
        chk("rk10.fips", rk_data, FIPS_RK10);
        tick();
        chk("rk.valid_drop", rk_valid, 1'b0);

        // Out-of-range indices
        rk_check(4'd11, "rk11");
        rk_check(4'd15, "rk15");
        for (int i = 0; i < 6; i++) rk_check(4'($urandom_range(0, 15)), "rk_rand");

        // Cache hit: same key re-offered
        key = FIPS_KEY; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        chk("hit.ack", key_ack, 1'b1);
        chk("hit.start", ke_start, 1'b0);
        chk("hit.kr", key_ready, 1'b1);
        tick();
        chk("hit.ack_pulse", key_ack, 1'b0);
        chk("hit.start2", ke_start, 1'b0);
        chk("hit.kr2", key_ready, 1'b1);
        rk_check(4'd1, "hit.rk1");

        // Rekey with a different key; same-cycle request served from the old key
        k = rnd_key();
        d = $urandom_range(3, 20);
        eng_delay = d; key = k; key_valid = 1'b1;
        rk_req = 1'b1; rk_round = 4'd1;
        tick();
        key_valid = 1'b0; rk_req = 1'b0;
        chk("rekey.old_valid", rk_valid, 1'b1);
        chk("rekey.old_data", rk_data, FIPS_RK1);
        chk("rekey.ack", key_ack, 1'b1);
        chk("rekey.start", ke_start, 1'b1);
        chk("rekey.kr", key_ready, 1'b0);
        model_key = k; model_ready = 1'b0;
        finish_load(d, 0, "rekey");
        for (int i = 0; i < 4; i++) rk_check(4'($urandom_range(0, 15)), "rekey.rk");

        // Key held during WAIT is not acked until READY
        start_load(rnd_key(), 10, "held");
        k = rnd_key();
        key = k; key_valid = 1'b1; eng_delay = 7;
        early = 1'b0; n = 0;
        do begin
            tick();
            n++;
            if (key_ack === 1'b1) early = 1'b1;
        end while (!key_ready && n < 300);
        chk("held.no_early_ack", early, 1'b0);
        chk("held.lat", n, 11);
        tick();
        key_valid = 1'b0;
        chk("held.ack", key_ack, 1'b1);
        chk("held.start", ke_start, 1'b1);
        chk("held.kekey", ke_key, k);
        chk("held.kr", key_ready, 1'b0);
        model_key = k; model_ready = 1'b0;
        rk_check(4'd5, "wait.rk");
        finish_load(7, 1, "held2");
        rk_check(4'($urandom_range(0, 10)), "held2.rk");

        // Watchdog: engine never completes
        start_load(rnd_key(), -1, "wd");
        n = 0;
        do begin
            tick();
            n++;
        end while (err !== 1'b1 && n < 300);
        chk("wd.err_lat", n, TMO);
        chk("wd.kr", key_ready, 1'b0);
        chk("wd.busy", busy, 1'b0);
        rk_check(4'd3, "wd.rk");

        // Recovery from ERROR, completing on the last watchdog cycle
        k = rnd_key();
        eng_delay = TMO - 1; key = k; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        chk("rec.ack", key_ack, 1'b1);
        chk("rec.ke_reset", ke_reset, 1'b1);
        chk("rec.start_early", ke_start, 1'b0);
        chk("rec.err_clr", err, 1'b0);
        chk("rec.kekey", ke_key, k);
        tick();
        chk("rec.start", ke_start, 1'b1);
        chk("rec.ke_reset_pulse", ke_reset, 1'b0);
        chk("rec.busy", busy, 1'b1);
        model_key = k; model_ready = 1'b0;
        finish_load(TMO - 1, 0, "bound");
        for (int i = 0; i < 3; i++) rk_check(4'($urandom_range(0, 15)), "bound.rk");

        // Asynchronous reset in the middle of WAIT
        k = rnd_key();
        start_load(k, 30, "ar");
        tick();
        tick();
        chk("ar.busy_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.busy", busy, 1'b0);
        chk("ar.ke_reset", ke_reset, 1'b1);
        chk("ar.key_ack", key_ack, 1'b0);
        chk("ar.ke_start", ke_start, 1'b0);
        chk("ar.kr", key_ready, 1'b0);
        chk("ar.err", err, 1'b0);
        model_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar.ke_reset_rel", ke_reset, 1'b0);
        chk("ar.idle_busy", busy, 1'b0);
        start_load(k, 4, "post");
        finish_load(4, 0, "post");
        rk_check(4'($urandom_range(0, 10)), "post.rk");
        rk_check(4'd12, "post.rk12");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Controller that sequences the AES-128 key expansion engine and serves round keys to the cipher core. It accepts a new cipher key with a valid/ack handshake and starts the expansion engine. It waits for completion under a watchdog, then answers per-round key requests from the round datapath. It sits between the key-load interface and the key_expansion / round datapath pair.

Parameters:
ROUNDS_P, 10, number of AES rounds; round keys indexed 0..ROUNDS_P.
TIMEOUT_P, 64, maximum cycles in WAIT before error.
CACHE_EN_P, 1, when 1, a key equal to the cached key is acked without re-expansion.

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
key_valid  in  1  new key offered; held until key_ack.
key  in  128  cipher key, w0 in bits [127:96].
key_ack  out  1  one-cycle pulse when key accepted.
ke_reset  out  1  active-high synchronous reset to the expansion engine.
ke_start  out  1  one-cycle start pulse to the expansion engine.
ke_key  out  128  key presented to the engine; registered, stable from ke_start until ke_done.
ke_exp_key  in  (ROUNDS_P+1)*128  expanded key bus; round r occupies [r*128 +: 128].
ke_done  in  1  engine completion pulse.
rk_req  in  1  round-key request.
rk_round  in  4  requested round index.
rk_valid  out  1  round-key response valid.
rk_data  out  128  round key.
rk_err  out  1  response flag: index > ROUNDS_P.
key_ready  out  1  high while round keys are valid (READY).
busy  out  1  high in START or WAIT.
err  out  1  sticky watchdog timeout flag.

Behaviour:
- Reset (reset=0, async) sets:
  - state=IDLE; every output 0 except ke_reset=1.
  - cache_valid=0; watchdog counter=0.
- ke_reset deasserts on the first clock edge after reset releases.
- States: IDLE, START, WAIT, READY, ERROR.
- IDLE: on key_valid, pulse key_ack, latch key into ke_key, go to START.
- START (exactly 1 cycle): ke_start=1, busy=1, clear watchdog, go to WAIT.
- WAIT:
  - busy=1; the watchdog increments every cycle.
  - ke_done=1 → go to READY, cache_valid=1, key_ready=1 from the next cycle.
  - Watchdog reaches TIMEOUT_P-1 without ke_done → go to ERROR, set err=1, cache_valid=0.
  - key_valid is not acked in WAIT (requester holds it).
  - ke_done is checked before the watchdog; if both happen in the same cycle, go to READY.
- READY, on key_valid:
  - CACHE_EN_P=1 and key==ke_key: pulse key_ack, stay in READY, key_ready stays 1.
  - Otherwise: pulse key_ack, latch the new key, key_ready=0 next cycle, go to START.
- ERROR:
  - err=1, key_ready=0.
  - On key_valid: pulse key_ack, latch the key, drive ke_reset=1 for one cycle, clear err, then go to START.
- Round-key port (registered, 1-cycle latency):
  - rk_req in cycle N while READY → in cycle N+1, rk_valid=1.
  - rk_round<=ROUNDS_P: rk_data=ke_exp_key[rk_round*128 +: 128], rk_err=0.
  - rk_round>ROUNDS_P: rk_data=0, rk_err=1.
  - rk_req outside READY: rk_valid=0, rk_err=0 (request dropped; the core must wait for key_ready).
  - In the cycle READY is left for a rekey, a same-cycle rk_req is still served from the old key.
- Reset mid-operation: immediate return to IDLE; an in-flight expansion is abandoned via ke_reset.
- Widths:
  - The watchdog is clog2(TIMEOUT_P)+1 bits and saturates.
  - rk_round is compared unsigned, full 4 bits.

Decomposition:
- Shared package aes_pkg holds:
  - state encoding constants;
  - AES_KEY_W=128, AES_ROUNDS=10;
  - the FIPS-197 test vectors used by benches.
- One natural sub-module: aes_rk_mux. It is the registered round-key select/response stage (rk_req/rk_round → rk_valid/rk_data/rk_err), gated by key_ready.

Test Plan:
- Basic load:
  - Stimulus: reset, then key=128'h2b7e151628aed2a6abf7158809cf4f3c with the real key_expansion attached.
  - Required: key_ack 1 cycle; ke_start 1 cycle; busy until ke_done; key_ready=1.
  - Then rk_round=0 → 2b7e...4f3c, rk_round=1 → a0fafe1788542cb123a339392a6c7605, rk_round=10 → d014f9a8c9ee2589e13f0cc8b6630ca6, each one cycle after rk_req.
- Bad index: in READY, rk_round=11 and 15 → rk_valid=1, rk_err=1, rk_data=0.
- Cache hit: the same key re-offered in READY → key_ack pulse, no ke_start, key_ready stays 1. A different key → ke_start, key_ready drops until ke_done.
- Watchdog:
  - Stimulus: engine model never asserts ke_done.
  - Required: err=1 exactly TIMEOUT_P cycles after ke_start; key_ready=0; rk_req gets no rk_valid.
  - Then a new key → key_ack, ke_reset 1 cycle, ke_start, err cleared.
- Held key / async reset:
  - key_valid held during WAIT → no key_ack until READY, then accepted.
  - Async reset asserted mid-WAIT between clock edges → outputs clear immediately, ke_reset=1, state IDLE.
- Boundary: ke_done on the final watchdog cycle → READY, err stays 0.
